// File: rtl/bht_pkg.sv
// Shared types for the branch history table update scheduler: arbiter states,
// the buffered update entry, and the PC-to-row mapping.
package bht_pkg;

    localparam int ADDR_W = 5;
    localparam int ROW_W  = ADDR_W - 2;

    // Consecutive deferred writes tolerated before the write side is forced through.
    localparam logic [1:0] DEFER_LIMIT = 2'd3;

    typedef enum logic [1:0] {
        NORMAL,
        FORCE_WR,
        FLUSH
    } state_e;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic              taken;
        logic              jumped;
    } upd_entry_t;

    // Word-aligned PC index: the low two bits never select a table row.
    function automatic logic [ROW_W-1:0] row_of(input logic [ADDR_W-1:0] a);
        return a[ADDR_W-1:2];
    endfunction

endpackage

// File: rtl/bht_update_fifo.sv
// Update FIFO: push/pop/flush, count-based full/empty, every slot exposed for lookup.
// Head is combinational from storage; a push is never visible at the head in the same cycle.
module bht_update_fifo #(
    parameter  int DEPTH = 4,
    parameter  int WIDTH = 7,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        flush_i,
    input  logic                        push_i,
    input  logic                        pop_i,
    input  logic [WIDTH-1:0]            push_dat_i,
    output logic [WIDTH-1:0]            head_dat_o,
    output logic [DEPTH-1:0][WIDTH-1:0] entries_o,
    output logic [DEPTH-1:0]            valid_o,
    output logic [CNT_W-1:0]            count_o
);

    logic [DEPTH-1:0][WIDTH-1:0] mem_q;
    logic [PTR_W-1:0]            wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]            rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]            count_q, count_d;
    logic [PTR_W-1:0]            off;

    always_comb begin
        wr_ptr_d = push_i ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop_i  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        case ({push_i, pop_i})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_i && !rst_i && !flush_i) begin
            mem_q[wr_ptr_q] <= push_dat_i;
        end
    end

    // A slot is live when its distance from the head is below the occupancy.
    always_comb begin
        off     = '0;
        valid_o = '0;
        for (int i = 0; i < DEPTH; i++) begin
            off        = PTR_W'(i) - rd_ptr_q;
            valid_o[i] = CNT_W'(off) < count_q;
        end
    end

    assign head_dat_o = mem_q[rd_ptr_q];
    assign entries_o  = mem_q;
    assign count_o    = count_q;

endmodule

// File: rtl/bht_update_scheduler.sv
// Arbitrates fetch reads against buffered branch updates on the BHT ports; grants are
// combinational, pred_valid follows a read grant by one cycle, updates stall when full.
module bht_update_scheduler
    import bht_pkg::*;
#(
    parameter  int LOWER = ADDR_W,
    parameter  int DEPTH = 4,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             rd_req,
    input  logic [LOWER-1:0] rd_addr,
    output logic             rd_grant,
    output logic             pending_hit,
    input  logic             upd_valid,
    input  logic [LOWER-1:0] upd_addr,
    input  logic             upd_taken,
    input  logic             upd_jumped,
    output logic             upd_ready,
    output logic             bht_rd_en,
    output logic [LOWER-1:0] bht_rd_addr,
    output logic             bht_wr_en,
    output logic [LOWER-1:0] bht_wr_addr,
    output logic             bht_was_taken,
    output logic             bht_jumped,
    output logic             pred_valid,
    output logic [CNT_W-1:0] count,
    output logic             overflow
);

    localparam int               ENT_W = $bits(upd_entry_t);
    localparam logic [CNT_W-1:0] FULL  = CNT_W'(DEPTH);

    state_e                      state_q, state_d;
    logic [1:0]                  defer_q, defer_d;
    logic                        overflow_q, overflow_d;
    logic                        pred_valid_q;
    logic                        wr_grant, push, not_empty, conflict, hit;
    upd_entry_t                  push_ent, head_ent, ent_i;
    logic [DEPTH-1:0][ENT_W-1:0] entries;
    logic [DEPTH-1:0]            ent_vld;

    assign push_ent  = '{addr: upd_addr, taken: upd_taken, jumped: upd_jumped};
    assign not_empty = count != '0;
    assign conflict  = rd_req && not_empty && (row_of(rd_addr) == row_of(head_ent.addr));
    assign upd_ready = !rst && (count < FULL) && !flush && (state_q != FLUSH);
    assign push      = upd_valid && upd_ready;

    bht_update_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENT_W)
    ) u_fifo (
        .clk_i      (clk),
        .rst_i      (rst),
        .flush_i    (flush),
        .push_i     (push),
        .pop_i      (wr_grant),
        .push_dat_i (push_ent),
        .head_dat_o (head_ent),
        .entries_o  (entries),
        .valid_o    (ent_vld),
        .count_o    (count)
    );

    always_comb begin
        state_d  = state_q;
        defer_d  = defer_q;
        rd_grant = 1'b0;
        wr_grant = 1'b0;
        case (state_q)
            FORCE_WR: begin
                wr_grant = not_empty;
                defer_d  = '0;
                state_d  = NORMAL;
            end
            default: begin
                state_d  = NORMAL;
                rd_grant = rd_req;
                if (conflict) begin
                    if (defer_q != DEFER_LIMIT) defer_d = defer_q + 2'd1;
                    if (defer_d == DEFER_LIMIT || count == FULL) state_d = FORCE_WR;
                end else begin
                    wr_grant = not_empty;
                end
            end
        endcase
        if (wr_grant) defer_d = '0;
        // Flush drops the write side but keeps fetch fed.
        if (flush) begin
            wr_grant = 1'b0;
            rd_grant = rd_req;
            defer_d  = '0;
            state_d  = FLUSH;
        end
        if (rst) begin
            rd_grant = 1'b0;
            wr_grant = 1'b0;
        end
    end

    assign overflow_d = overflow_q | (upd_valid && !upd_ready && !flush);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= NORMAL;
            defer_q      <= '0;
            overflow_q   <= 1'b0;
            pred_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            defer_q      <= defer_d;
            overflow_q   <= overflow_d;
            pred_valid_q <= rd_grant;
        end
    end

    always_comb begin
        hit   = 1'b0;
        ent_i = '0;
        for (int i = 0; i < DEPTH; i++) begin
            ent_i = entries[i];
            if (ent_vld[i] && row_of(ent_i.addr) == row_of(rd_addr)) hit = 1'b1;
        end
    end

    assign pending_hit   = rd_req && hit;
    assign bht_rd_en     = rd_grant;
    assign bht_rd_addr   = rd_addr;
    assign bht_wr_en     = wr_grant;
    assign bht_wr_addr   = head_ent.addr;
    assign bht_was_taken = head_ent.taken;
    assign bht_jumped    = head_ent.jumped;
    assign pred_valid    = pred_valid_q;
    assign overflow      = overflow_q;

endmodule

// File: tb/tb_bht_update_scheduler.sv
// Directed scenarios plus a random update stream; table writes are scoreboarded in order.
module tb_bht_update_scheduler;

    logic       clk;
    logic       rst, flush, rd_req, upd_valid, upd_taken, upd_jumped;
    logic [4:0] rd_addr, upd_addr;
    logic       rd_grant, pending_hit, upd_ready, bht_rd_en, bht_wr_en;
    logic [4:0] bht_rd_addr, bht_wr_addr;
    logic       bht_was_taken, bht_jumped, pred_valid, overflow;
    logic [2:0] count;

    typedef struct {
        logic [4:0] a;
        logic       t;
        logic       j;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    bht_update_scheduler #(.LOWER(5), .DEPTH(4)) dut (
        .clk           (clk),
        .rst           (rst),
        .flush         (flush),
        .rd_req        (rd_req),
        .rd_addr       (rd_addr),
        .rd_grant      (rd_grant),
        .pending_hit   (pending_hit),
        .upd_valid     (upd_valid),
        .upd_addr      (upd_addr),
        .upd_taken     (upd_taken),
        .upd_jumped    (upd_jumped),
        .upd_ready     (upd_ready),
        .bht_rd_en     (bht_rd_en),
        .bht_rd_addr   (bht_rd_addr),
        .bht_wr_en     (bht_wr_en),
        .bht_wr_addr   (bht_wr_addr),
        .bht_was_taken (bht_was_taken),
        .bht_jumped    (bht_jumped),
        .pred_valid    (pred_valid),
        .count         (count),
        .overflow      (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%0d want=%0d", tag, got, want);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    // Drive an update offer; acc says whether the bench expects it to be accepted.
    task automatic offer(input logic v, input logic [4:0] a, input logic t, input logic j,
                         input logic acc);
        exp_t e;
        upd_valid  = v;
        upd_addr   = a;
        upd_taken  = t;
        upd_jumped = j;
        if (v && acc) begin
            e.a = a;
            e.t = t;
            e.j = j;
            exp_q.push_back(e);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst && bht_wr_en === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("wr_spurious", 32'(bht_wr_addr), 32'd99);
            end else begin
                e = exp_q.pop_front();
                chk("sb_wr_addr", 32'(bht_wr_addr), 32'(e.a));
                chk("sb_wr_taken", 32'(bht_was_taken), 32'(e.t));
                chk("sb_wr_jump", 32'(bht_jumped), 32'(e.j));
            end
        end
    end

    initial begin
        logic       v;
        logic [4:0] a;
        rst = 1'b1; flush = 1'b0; rd_req = 1'b1; rd_addr = 5'd0;
        offer(1'b0, 5'd0, 1'b0, 1'b0, 1'b0);

        // Reset: all enables gated even with a request present.
        cyc(); mid();
        chk("rst_rd_grant", 32'(rd_grant), 0);
        chk("rst_upd_ready", 32'(upd_ready), 0);
        chk("rst_bht_rd_en", 32'(bht_rd_en), 0);
        cyc(); mid();
        chk("rst_count", 32'(count), 0);
        chk("rst_overflow", 32'(overflow), 0);
        chk("rst_pred_valid", 32'(pred_valid), 0);
        chk("rst_wr_en", 32'(bht_wr_en), 0);
        cyc(); rst = 1'b0; rd_req = 1'b0;

        // Basic update.
        cyc(); offer(1'b1, 5'd5, 1'b1, 1'b0, 1'b1); mid();
        chk("b_ready", 32'(upd_ready), 1);
        chk("b_no_bypass", 32'(bht_wr_en), 0);
        cyc(); offer(1'b0, 5'd0, 1'b0, 1'b0, 1'b0); mid();
        chk("b_wr_en", 32'(bht_wr_en), 1);
        chk("b_wr_addr", 32'(bht_wr_addr), 5);
        chk("b_taken", 32'(bht_was_taken), 1);
        chk("b_count1", 32'(count), 1);
        cyc(); mid();
        chk("b_count0", 32'(count), 0);
        chk("b_idle_wr", 32'(bht_wr_en), 0);

        // No conflict: rows 0 and 2 proceed together.
        cyc(); offer(1'b1, 5'd8, 1'b0, 1'b1, 1'b1);
        cyc(); offer(1'b0, 5'd0, 1'b0, 1'b0, 1'b0); rd_req = 1'b1; rd_addr = 5'd0; mid();
        chk("nc_rd_grant", 32'(rd_grant), 1);
        chk("nc_rd_addr", 32'(bht_rd_addr), 0);
        chk("nc_wr_en", 32'(bht_wr_en), 1);
        chk("nc_pend_hit", 32'(pending_hit), 0);
        cyc(); rd_req = 1'b0; mid();
        chk("nc_pred_valid", 32'(pred_valid), 1);
        chk("nc_count", 32'(count), 0);

        // Conflict and starvation: row 1 on both sides.
        cyc(); offer(1'b1, 5'd6, 1'b0, 1'b0, 1'b1);
        cyc(); offer(1'b0, 5'd0, 1'b0, 1'b0, 1'b0); rd_req = 1'b1; rd_addr = 5'd4;
        for (int i = 1; i <= 3; i++) begin
            mid();
            chk($sformatf("cf_rd_grant_%0d", i), 32'(rd_grant), 1);
            chk($sformatf("cf_wr_def_%0d", i), 32'(bht_wr_en), 0);
            chk($sformatf("cf_pend_%0d", i), 32'(pending_hit), 1);
            cyc();
        end
        mid();
        chk("cf_force_rd", 32'(rd_grant), 0);
        chk("cf_force_wr", 32'(bht_wr_en), 1);
        cyc(); mid();
        chk("cf_resume_rd", 32'(rd_grant), 1);
        chk("cf_pv_after_force", 32'(pred_valid), 0);
        chk("cf_empty_wr", 32'(bht_wr_en), 0);

        // Full FIFO under a conflicting read (rd_addr 4 still held).
        for (int i = 0; i < 4; i++) begin
            cyc(); offer(1'b1, 5'(4 + i), 1'(i), 1'(i >> 1), 1'b1); mid();
            chk($sformatf("ff_ready_%0d", i), 32'(upd_ready), 1);
        end
        cyc(); offer(1'b1, 5'd9, 1'b1, 1'b1, 1'b0); mid();
        chk("ff_count4", 32'(count), 4);
        chk("ff_ready_full", 32'(upd_ready), 0);
        chk("ff_force_rd", 32'(rd_grant), 0);
        chk("ff_force_wr", 32'(bht_wr_en), 1);
        cyc(); offer(1'b0, 5'd0, 1'b0, 1'b0, 1'b0); mid();
        chk("ff_overflow", 32'(overflow), 1);
        chk("ff_count3", 32'(count), 3);
        chk("ff_ready_freed", 32'(upd_ready), 1);
        chk("ff_defer_again", 32'(bht_wr_en), 0);

        // Flush with three pending and a concurrent offer.
        cyc(); flush = 1'b1; offer(1'b1, 5'd9, 1'b0, 1'b0, 1'b0); mid();
        chk("fl_wr_en", 32'(bht_wr_en), 0);
        chk("fl_ready", 32'(upd_ready), 0);
        chk("fl_rd_grant", 32'(rd_grant), 1);
        chk("fl_count_before", 32'(count), 3);
        exp_q.delete();
        cyc(); flush = 1'b0; rd_req = 1'b0; offer(1'b0, 5'd0, 1'b0, 1'b0, 1'b0); mid();
        chk("fl_count0", 32'(count), 0);
        chk("fl_ready_hold", 32'(upd_ready), 0);
        chk("fl_pred_valid", 32'(pred_valid), 1);
        cyc(); mid();
        chk("fl_ready_back", 32'(upd_ready), 1);
        chk("fl_ovf_sticky", 32'(overflow), 1);

        // Reset mid-operation with two pending.
        cyc(); offer(1'b1, 5'd4, 1'b1, 1'b0, 1'b1);
        cyc(); offer(1'b1, 5'd12, 1'b0, 1'b1, 1'b1); rd_req = 1'b1; rd_addr = 5'd4;
        cyc(); offer(1'b0, 5'd0, 1'b0, 1'b0, 1'b0); rst = 1'b1; mid();
        chk("mr_count2", 32'(count), 2);
        chk("mr_ovf1", 32'(overflow), 1);
        chk("mr_rd_grant", 32'(rd_grant), 0);
        chk("mr_wr_en", 32'(bht_wr_en), 0);
        chk("mr_ready", 32'(upd_ready), 0);
        exp_q.delete();
        cyc(); rst = 1'b0; rd_req = 1'b0; mid();
        chk("mr_count0", 32'(count), 0);
        chk("mr_ovf0", 32'(overflow), 0);
        chk("mr_pred_valid", 32'(pred_valid), 0);
        chk("mr_wr_idle", 32'(bht_wr_en), 0);

        // Random update stream with no reads: every offer must be accepted and written in order.
        for (int i = 0; i < 40; i++) begin
            v = 1'($urandom_range(0, 1));
            a = 5'($urandom_range(0, 31));
            cyc(); offer(v, a, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1); mid();
            if (v) chk("rnd_ready", 32'(upd_ready), 1);
        end
        cyc(); offer(1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        repeat (3) cyc();
        mid();
        chk("sb_drained", 32'(exp_q.size()), 0);
        chk("end_overflow", 32'(overflow), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bht_update_scheduler.md
# bht_update_scheduler

Schedules access to the branch history table from fetch and execute. Fetch-side prediction reads are arbitrated against resolved-branch updates, which are buffered in a small FIFO and retired one per cycle into the table's write side. The block sits between the fetch/execute stages and a branch history table revision with separate read-enable and write-enable ports.

## Interface
- `LOWER`, 5: PC index bits. Table row = `addr[LOWER-1:2]`.
- `DEPTH`, 4: update FIFO entries. Must be a power of two, ≥2.
- `clk` in 1: clock, rising edge.
- `rst` in 1: reset. Synchronous, active-high.
- `flush` in 1: discard all pending updates.
- `rd_req` in 1: fetch requests a prediction.
- `rd_addr` in LOWER: fetch index.
- `rd_grant` out 1: read issued this cycle.
- `pending_hit` out 1: `rd_req` row matches the row of any valid FIFO entry.
- `upd_valid` in 1: execute offers a resolved branch.
- `upd_addr` in LOWER: branch index.
- `upd_taken` in 1: branch was taken.
- `upd_jumped` in 1: unconditional jump.
- `upd_ready` out 1: FIFO accepts the offer.
- `bht_rd_en` out 1: read enable to the table.
- `bht_rd_addr` out LOWER: read index to the table.
- `bht_wr_en` out 1: write enable to the table.
- `bht_wr_addr` out LOWER: write index to the table.
- `bht_was_taken` out 1: taken flag for the table write.
- `bht_jumped` out 1: jump flag for the table write.
- `pred_valid` out 1: the table's prediction output is valid (`rd_grant` delayed one cycle).
- `count` out $clog2(DEPTH+1): number of FIFO entries.
- `overflow` out 1: sticky error flag; cleared only by `rst`.

## Operation
- **Push.** `upd_ready = (count < DEPTH) && !flush && state != FLUSH`. On `upd_valid && upd_ready`, push {addr, taken, jumped}.
- **Overflow.** `upd_valid && !upd_ready && !flush` does not push and sets `overflow`. A dropped update is a protocol error by the requester.
- **Write side.** `bht_wr_*` is driven combinationally from the FIFO head. `bht_wr_en` asserts only when `count > 0` and the arbiter grants the write. A granted write pops the head.
- **Read side.** `bht_rd_en = rd_grant`; `bht_rd_addr = rd_addr`.
- **Conflict.** A conflict is `rd_req`, `count > 0`, and row(`rd_addr`) == row(head).
- **No conflict.** Read and write are both granted in the same cycle.
- **Conflict resolution.** Policy is set by the FSM:
  - NORMAL: read wins; the write is deferred and `defer_cnt` increments.
  - NORMAL → FORCE_WR when `defer_cnt` reaches 3, or when `count == DEPTH` with a conflict.
  - FORCE_WR: lasts one cycle. The write wins, `rd_grant = 0`, `defer_cnt` clears, then return to NORMAL.
- **defer_cnt.** 2 bits. Clears on any granted write.
- **Flush.**
  - Any state → FLUSH when `flush`. In that cycle: `bht_wr_en = 0`, no push, no pop; the read is still granted.
  - Next cycle `count = 0`, FIFO pointers reset, `defer_cnt = 0`.
  - FLUSH → NORMAL after one cycle unless `flush` is still high.
- **pending_hit.** Combinational compare of row(`rd_addr`) against all valid entries, gated by `rd_req`.
- **Pointers.** Wrap modulo DEPTH. Full/empty are decided by `count`, not by pointer equality.

## Timing
- **Reset values.** `count = 0`, pointers = 0, state = NORMAL, `defer_cnt = 0`, `overflow = 0`, `pred_valid = 0`. All `bht_*_en`, `rd_grant` and `upd_ready` are 0 while `rst` is high.
- **Update latency.** An update pushed in cycle N is written no earlier than cycle N+1. There is no bypass from `upd_*` to `bht_wr_*`.
- **Read latency.** `rd_grant` in cycle N gives `pred_valid` in cycle N+1. The table registers its prediction on the same edge.
- **Simultaneous push and pop.** When `count < DEPTH`, `count` is unchanged.
- **Full FIFO.** At `count == DEPTH` a pop still occurs; the freed slot is visible through `upd_ready` only in the next cycle.
- **Mid-operation reset.** Reset mid-operation discards FIFO contents and clears `overflow`.
- **Registered outputs.** `rd_grant`, `upd_ready` and `bht_*` are combinational. `pred_valid`, `count` and `overflow` are registered.

## Structure
- **Package `bht_pkg`:**
  - state enum {NORMAL, FORCE_WR, FLUSH};
  - update entry struct {addr, taken, jumped};
  - `DEFER_LIMIT = 3`;
  - row-extract function.
- **Sub-module `bht_update_fifo`:**
  - parameterized DEPTH/width;
  - push/pop/flush;
  - outputs `count` and the valid-entry vector;
  - exposes all entries for the `pending_hit` compare.
- **Top level:** holds the arbiter FSM, `defer_cnt`, `overflow`, and the `pred_valid` register.

## Test plan
- **Basic update.** Push addr 5 taken in cycle 1 → `bht_wr_en = 1`, `bht_wr_addr = 5`, `bht_was_taken = 1` in cycle 2; `count` back to 0 in cycle 3.
- **No conflict.** `rd_req` addr 0 with head addr 8 → both granted in one cycle; `pred_valid = 1` the next cycle.
- **Conflict and starvation.** `rd_req` addr 4 held with head addr 6 (same row 1) → write deferred 3 cycles; FSM enters FORCE_WR on cycle 4 with `rd_grant = 0` and write 6; reads resume on cycle 5.
- **Full FIFO.** Push 4 updates while a conflicting read holds off writes → `upd_ready = 0` at `count = 4`. A 5th `upd_valid` sets `overflow = 1`; FORCE_WR then pops one entry.
- **Flush.** Flush with `count = 3` and a concurrent `upd_valid` → no write and no push; next cycle `count = 0`, `upd_ready = 0`; the cycle after that, NORMAL with `upd_ready = 1`.
- **Reset mid-operation.** Assert `rst` mid-stream with `count = 2` and `overflow = 1` → next cycle `count = 0`, `overflow = 0`, all enables 0.
